// File: rtl/key_mode_sel.sv
// Debounced push-button front end: short press steps the 2-bit LED mode,
// long press returns it to 0.
module key_mode_sel #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_n,
   output logic [1:0] mode,
   output logic       mode_stb,
   output logic       long_stb,
   output logic       key_pressed
);

   localparam int              DBW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DBW-1:0]  DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0]     LONG_LAST = 32'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_t;

   logic           sync1_r;
   logic           sync2_r;
   logic           stable_r;
   logic [DBW-1:0] db_cnt_r;
   logic           key_pressed_r;
   logic [31:0]    hold_cnt_r;
   state_t         state_r;
   logic [1:0]     mode_r;
   logic           mode_stb_r;
   logic           long_stb_r;

   logic           differ_s;
   logic           db_last_s;
   logic           long_hit_s;

   // Debounce comparisons against the synchronised key level
   always_comb begin
      differ_s   = sync2_r ^ stable_r;
      db_last_s  = (db_cnt_r == DB_LAST);
      long_hit_s = (hold_cnt_r == LONG_LAST);
   end

   // Synchroniser, debounce counter and debounced key level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r       <= 1'b1;
         sync2_r       <= 1'b1;
         stable_r      <= 1'b1;
         db_cnt_r      <= '0;
         key_pressed_r <= 1'b0;
      end else begin
         sync1_r       <= key_n;
         sync2_r       <= sync1_r;
         key_pressed_r <= ~stable_r;
         if (!differ_s) begin
            db_cnt_r <= '0;
         end else if (!db_last_s) begin
            db_cnt_r <= db_cnt_r + DBW'(1);
         end else begin
            // a full run of disagreeing samples: accept the new level
            stable_r <= sync2_r;
            db_cnt_r <= '0;
         end
      end
   end

   // Press classification FSM with registered mode and strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         hold_cnt_r <= 32'd0;
         mode_r     <= 2'd0;
         mode_stb_r <= 1'b0;
         long_stb_r <= 1'b0;
      end else begin
         mode_stb_r <= 1'b0;
         long_stb_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (!stable_r) begin
                  state_r    <= PRESSED;
                  hold_cnt_r <= 32'd0;
               end
            end
            PRESSED: begin
               hold_cnt_r <= hold_cnt_r + 32'd1;
               // release wins over the long threshold in the same cycle
               if (stable_r) begin
                  state_r    <= IDLE;
                  mode_r     <= mode_r + 2'd1;
                  mode_stb_r <= 1'b1;
               end else if (long_hit_s) begin
                  state_r    <= LONG;
                  mode_r     <= 2'd0;
                  mode_stb_r <= 1'b1;
                  long_stb_r <= 1'b1;
               end
            end
            LONG: begin
               if (stable_r) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign mode        = mode_r;
   assign mode_stb    = mode_stb_r;
   assign long_stb    = long_stb_r;
   assign key_pressed = key_pressed_r;

endmodule

// File: tb/tb_key_mode_sel.sv
// Bench for key_mode_sel: directed phases plus random key activity, checked
// every cycle against a press-duration reference model.
module tb_key_mode_sel;

   localparam int DB = 4;
   localparam int LG = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_n;
   logic [1:0] mode;
   logic       mode_stb;
   logic       long_stb;
   logic       key_pressed;

   int checks   = 0;
   int failures = 0;

   key_mode_sel #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_n),
      .mode       (mode),
      .mode_stb   (mode_stb),
      .long_stb   (long_stb),
      .key_pressed(key_pressed)
   );

   always #5 clk = ~clk;

   // reference model state
   bit         raw_q[$];
   int         edge_n;
   bit         m_stable;
   bit         m_kp;
   bit         m_pressing;
   bit         m_long_done;
   int         m_start;
   logic [1:0] m_mode;
   bit         m_mstb;
   bit         m_lstb;

   int obs_mstb;
   int obs_lstb;
   int obs_kp;
   int lstb_edge;
   int mstb_edge;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      raw_q.delete();
      edge_n      = 0;
      m_stable    = 1'b1;
      m_kp        = 1'b0;
      m_pressing  = 1'b0;
      m_long_done = 1'b0;
      m_start     = 0;
      m_mode      = 2'd0;
      m_mstb      = 1'b0;
      m_lstb      = 1'b0;
   endtask

   // key level seen by the debouncer at edge n: raw sample two edges earlier
   function automatic bit synced_at(input int n);
      if (n < 2) return 1'b1;
      return raw_q[n-2];
   endfunction

   task automatic model_edge(input bit k);
      bit old_stable;
      bit flip;
      old_stable = m_stable;
      raw_q.push_back(k);
      // the level is accepted once the last DB synchronised samples all disagree
      flip = 1'b1;
      for (int i = 0; i < DB; i++) begin
         if (synced_at(edge_n - i) == old_stable) flip = 1'b0;
      end
      if (flip) m_stable = ~old_stable;
      m_kp   = ~old_stable;
      m_mstb = 1'b0;
      m_lstb = 1'b0;
      if (!m_pressing) begin
         if (!old_stable) begin
            m_pressing  = 1'b1;
            m_long_done = 1'b0;
            m_start     = edge_n;
         end
      end else if (old_stable) begin
         m_pressing = 1'b0;
         if (!m_long_done) begin
            m_mode = m_mode + 2'd1;
            m_mstb = 1'b1;
         end
      end else if (!m_long_done && (edge_n - m_start == LG)) begin
         m_long_done = 1'b1;
         m_mode      = 2'd0;
         m_mstb      = 1'b1;
         m_lstb      = 1'b1;
      end
      edge_n++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(key_n);
      @(negedge clk);
      check("mode", 32'(mode), 32'(m_mode));
      check("mode_stb", 32'(mode_stb), 32'(m_mstb));
      check("long_stb", 32'(long_stb), 32'(m_lstb));
      check("key_pressed", 32'(key_pressed), 32'(m_kp));
      if (mode_stb) begin
         obs_mstb++;
         mstb_edge = edge_n - 1;
      end
      if (long_stb) begin
         obs_lstb++;
         lstb_edge = edge_n - 1;
      end
      if (key_pressed) obs_kp++;
   endtask

   task automatic hold(input int n, input logic v);
      key_n = v;
      repeat (n) step();
   endtask

   task automatic do_reset(input logic k);
      key_n = k;
      rst   = 1'b1;
      #1;
      model_reset();
      check("rst_mode", 32'(mode), 32'd0);
      check("rst_mode_stb", 32'(mode_stb), 32'd0);
      check("rst_long_stb", 32'(long_stb), 32'd0);
      check("rst_key_pressed", 32'(key_pressed), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clear_obs();
      obs_mstb  = 0;
      obs_lstb  = 0;
      obs_kp    = 0;
      lstb_edge = -1;
      mstb_edge = -1;
   endtask

   initial begin
      logic [1:0] short_seq [4];
      int         e0;
      short_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
      rst   = 1'b1;
      key_n = 1'b0;
      clear_obs();
      @(negedge clk);

      // reset with the key held, then the held key is debounced as a press
      do_reset(1'b0);
      repeat (6) step();
      check("kp_after_6", 32'(key_pressed), 32'd0);
      step();
      check("kp_after_7", 32'(key_pressed), 32'd1);
      hold(12, 1'b1);

      // four short presses from mode 0 wrap back to 0
      do_reset(1'b1);
      for (int i = 0; i < 4; i++) begin
         clear_obs();
         hold(10, 1'b0);
         hold(12, 1'b1);
         check("short_mode", 32'(mode), 32'(short_seq[i]));
         check("short_mstb_cnt", 32'(obs_mstb), 32'd1);
         check("short_lstb_cnt", 32'(obs_lstb), 32'd0);
      end

      // bouncing key never settles long enough to count
      clear_obs();
      for (int i = 0; i < 20; i++) hold(2, (i % 2) ? 1'b1 : 1'b0);
      hold(12, 1'b1);
      check("bounce_mode", 32'(mode), 32'd0);
      check("bounce_mstb_cnt", 32'(obs_mstb), 32'd0);
      check("bounce_lstb_cnt", 32'(obs_lstb), 32'd0);
      check("bounce_kp_cnt", 32'(obs_kp), 32'd0);

      // long press from mode 2
      hold(10, 1'b0);
      hold(12, 1'b1);
      hold(10, 1'b0);
      hold(12, 1'b1);
      check("pre_long_mode", 32'(mode), 32'd2);
      clear_obs();
      e0 = edge_n;
      hold(40, 1'b0);
      check("long_edge", 32'(lstb_edge), 32'(e0 + 6 + LG));
      check("long_mstb_edge", 32'(mstb_edge), 32'(e0 + 6 + LG));
      check("long_mode", 32'(mode), 32'd0);
      hold(12, 1'b1);
      check("long_mstb_cnt", 32'(obs_mstb), 32'd1);
      check("long_lstb_cnt", 32'(obs_lstb), 32'd1);
      check("after_long_mode", 32'(mode), 32'd0);

      // release lands on the threshold cycle: short press
      clear_obs();
      hold(16, 1'b0);
      hold(12, 1'b1);
      check("bound_short_mode", 32'(mode), 32'd1);
      check("bound_short_lstb", 32'(obs_lstb), 32'd0);
      check("bound_short_mstb", 32'(obs_mstb), 32'd1);

      // one cycle longer: long press
      clear_obs();
      hold(17, 1'b0);
      hold(12, 1'b1);
      check("bound_long_mode", 32'(mode), 32'd0);
      check("bound_long_lstb", 32'(obs_lstb), 32'd1);

      // reset mid-press at hold count 8, key still held afterwards
      hold(10, 1'b0);
      hold(12, 1'b1);
      clear_obs();
      hold(15, 1'b0);
      do_reset(1'b0);
      check("midrst_mstb_cnt", 32'(obs_mstb), 32'd0);
      hold(30, 1'b0);
      hold(12, 1'b1);
      check("midrst_lstb_cnt", 32'(obs_lstb), 32'd1);

      // random key activity against the model
      for (int i = 0; i < 80; i++) begin
         hold(int'($urandom_range(1, 24)), 1'($urandom_range(0, 1)));
      end
      hold(12, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_mode_sel.md
# key_mode_sel

Debounced push-button front end that selects the LED display mode for the board status LEDs. It sits directly upstream of the 4-LED blinker and supplies a 2-bit mode selecting which LED pair counts: 0 = LEDs 1/2, 1 = LEDs 2/3, 2 = LEDs 3/4, 3 = LEDs 1/4. A short press advances the mode; a long press returns it to 0.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable samples required to accept a key level change (20 ms at 25 MHz); minimum 2.
- LONG_CYCLES, 25000000: hold time that counts as a long press (1 s at 25 MHz); must exceed 1.
- clk  input  1  system clock (25 MHz on board).
- rst  input  1  reset, asynchronous, active-high.
- key_n  input  1  raw push-button, active-low (0 = pressed), asynchronous to clk.
- mode  output  2  current LED mode, 0..3.
- mode_stb  output  1  one-cycle pulse on the cycle `mode` takes a new value.
- long_stb  output  1  one-cycle pulse when a long press is recognised.
- key_pressed  output  1  debounced key state, 1 = pressed.

## Operation
- Synchroniser: two flops on key_n; both reset to 1 (released).
- Debouncer: registered `stable` (reset 1) and counter `db_cnt` (reset 0).
  - When the sync output equals `stable`, db_cnt clears to 0.
  - When they differ and db_cnt != DEBOUNCE_CYCLES-1, db_cnt increments.
  - When they differ and db_cnt == DEBOUNCE_CYCLES-1, `stable` takes the sync value and db_cnt clears.
  - A single glitch cycle clears db_cnt; the count restarts from 0.
- key_pressed = ~stable, registered.
- FSM states:
  - IDLE (reset state): on stable == 0, go to PRESSED and clear hold_cnt.
  - PRESSED: hold_cnt increments every cycle.
    - If stable == 1 (released), go to IDLE, set mode <= mode + 1 mod 4 (3 wraps to 0), and pulse mode_stb.
    - Else if hold_cnt == LONG_CYCLES-1, go to LONG, pulse long_stb, set mode <= 0, and pulse mode_stb. mode_stb pulses even when mode was already 0.
  - LONG: wait only. On release, go to IDLE with no mode change and no strobe.
- Release takes priority over the long threshold in the same cycle, so that case is a short press.
- hold_cnt is 32-bit and is used only in PRESSED; it never wraps.

## Timing
- Reset values:
  - mode = 0, mode_stb = 0, long_stb = 0, key_pressed = 0.
  - FSM = IDLE, db_cnt = 0, hold_cnt = 0.
  - Both sync flops and `stable` = 1.
- Latency from a key_n edge to a `stable` change: 2 sync cycles + DEBOUNCE_CYCLES cycles of constant input.
- key_pressed changes 1 cycle after `stable`.
- The FSM samples registered `stable`. mode, mode_stb and long_stb update 1 cycle after `stable` changes and are all registered outputs.
- Long press: long_stb asserts LONG_CYCLES cycles after the PRESSED entry edge.
- Strobes are exactly 1 cycle wide. A new press cannot produce a strobe before 2·DEBOUNCE_CYCLES cycles have passed.
- Reset mid-press forces all state and outputs to reset values immediately, with no strobe. A key still held after reset is registered as a new press once debounced, because the synchroniser starts from 1.

## Test plan
Run the bench with DEBOUNCE_CYCLES = 4 and LONG_CYCLES = 16.
- Reset: assert rst with key_n = 0 → mode = 0, strobes = 0, key_pressed = 0. Release rst with key held → key_pressed = 1 after 2 + 4 + 1 cycles.
- Short press: hold key_n = 0 for 10 cycles, then release → mode goes 0→1 with one mode_stb pulse and no long_stb. Repeat 4 times → sequence 1, 2, 3, 0 (wrap).
- Bounce: toggle key_n every 2 cycles for 40 cycles, then return it high → stable never changes, mode is unchanged, no strobes.
- Long press from mode = 2: hold 40 cycles → long_stb and mode_stb coincide 16 cycles after PRESSED entry, mode = 0. Release → no further strobe, mode stays 0.
- Boundary: release so that stable rises on the same cycle hold_cnt == 15 → treated as short, mode increments, no long_stb.
- Reset mid-press: assert rst at hold_cnt = 8 → outputs at reset values immediately, no strobe, FSM in IDLE.
